// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stall polarity, buffer state encoding,
// and the default performance-counter width.
package pipe_pkg;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_VALID = 2'd1;
   localparam logic [1:0] ST_HELD  = 2'd2;

   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Stall-aware inter-stage pipeline register with flush/bubble/hold control.
// Define PIPE_STAGE_PERF_EN to build the bubble/hold performance counters.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 141,
   parameter int                STALL_W   = 6,
   parameter int                STAGE     = 2,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter int                CNT_W     = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [1:0]         out_state,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   hold_cnt
);

   generate
      if (STAGE > STALL_W - 2) begin : g_bad_stage
         $error("pipe_stage_buf: STAGE must be <= STALL_W-2");
      end
   endgenerate

   logic own_stop;
   logic next_stop;
   logic do_bubble;
   logic do_hold;
   logic stall_unused;

   // Only our bit and the downstream bit matter here.
   assign stall_unused = ^stall;
   assign own_stop     = (stall[STAGE] == STOP);
   assign next_stop    = (stall[STAGE+1] == STOP);
   assign do_bubble    = !flush && own_stop && !next_stop;
   assign do_hold      = !flush && own_stop && next_stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= NOP_VALUE;
         out_valid <= 1'b0;
         out_state <= ST_EMPTY;
      end else if (flush) begin
         out_data  <= NOP_VALUE;
         out_valid <= 1'b0;
         out_state <= ST_EMPTY;
      end else if (do_bubble) begin
         out_data  <= NOP_VALUE;
         out_valid <= 1'b0;
         out_state <= ST_EMPTY;
      end else if (do_hold) begin
         out_state <= (out_state == ST_EMPTY) ? ST_EMPTY : ST_HELD;
      end else begin
         out_data  <= in_data;
         out_valid <= in_valid;
         out_state <= in_valid ? ST_VALID : ST_EMPTY;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic bubble_inc;
   logic hold_inc;

   // A bubble only counts when it actually displaces a live instruction.
   assign bubble_inc = do_bubble && (out_valid || in_valid);
   assign hold_inc   = do_hold && (out_state != ST_EMPTY);

   pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc),
      .count (bubble_cnt)
   );

   pipe_sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hold_inc),
      .count (hold_cnt)
   );
`else
   assign bubble_cnt = '0;
   assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: directed vectors push expectations,
// a monitor pops and compares one cycle after each vector is applied.
module tb_pipe_stage_buf;

   localparam int DW = 141;

`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [5:0] ADV = 6'b000000;
   localparam logic [5:0] HLD = 6'b001100;
   localparam logic [5:0] BUB = 6'b000100;

   typedef struct {
      string          nm;
      logic           v;
      logic [DW-1:0]  d;
      logic [1:0]     s;
      int             b;
      int             h;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_state;
   logic [15:0]   bubble_cnt;
   logic [15:0]   hold_cnt;

   logic [5:0]    stall_b;
   logic          in_valid_b;
   logic [DW-1:0] in_data_b;
   logic          out_valid_b;
   logic [DW-1:0] out_data_b;
   logic [1:0]    out_state_b;
   logic [1:0]    bubble_cnt_b;
   logic [1:0]    hold_cnt_b;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_buf dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_state  (out_state),
      .bubble_cnt (bubble_cnt),
      .hold_cnt   (hold_cnt)
   );

   pipe_stage_buf #(.CNT_W(2)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall_b),
      .flush      (1'b0),
      .in_valid   (in_valid_b),
      .in_data    (in_data_b),
      .out_valid  (out_valid_b),
      .out_data   (out_data_b),
      .out_state  (out_state_b),
      .bubble_cnt (bubble_cnt_b),
      .hold_cnt   (hold_cnt_b)
   );

   function automatic int cexp(int n);
      return PERF ? n : 0;
   endfunction

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(string nm, logic [5:0] st, logic fl, logic iv,
                       logic [DW-1:0] d, logic ev, logic [DW-1:0] ed,
                       logic [1:0] es, int eb, int eh);
      exp_t e;
      @(negedge clk);
      stall    = st;
      flush    = fl;
      in_valid = iv;
      in_data  = d;
      e.nm = nm; e.v = ev; e.d = ed; e.s = es;
      e.b = cexp(eb); e.h = cexp(eh);
      sb.push_back(e);
   endtask

   // Monitor: compares registered outputs 2 time units after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, ".valid"}, DW'(out_valid), DW'(e.v));
            chk({e.nm, ".data"}, out_data, e.d);
            chk({e.nm, ".state"}, DW'(out_state), DW'(e.s));
            chk({e.nm, ".bub"}, DW'(bubble_cnt), DW'(e.b));
            chk({e.nm, ".hold"}, DW'(hold_cnt), DW'(e.h));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] big;
      big = {1'b1, 140'h5678};
      rst = 1'b1; stall = ADV; flush = 1'b0;
      in_valid = 1'b0; in_data = '0;
      stall_b = ADV; in_valid_b = 1'b0; in_data_b = '0;
      #3;
      chk("rst.valid", DW'(out_valid), '0);
      chk("rst.data", out_data, '0);
      chk("rst.state", DW'(out_state), '0);
      @(negedge clk);
      rst = 1'b0;

      step("adv1", ADV, 0, 1, 'h1234, 1, 'h1234, 1, 0, 0);
      step("hold1", HLD, 0, 1, 'h0bad, 1, 'h1234, 2, 0, 1);
      step("hold2", HLD, 0, 1, 'h0bad, 1, 'h1234, 2, 0, 2);
      step("hold3", HLD, 0, 1, 'h0bad, 1, 'h1234, 2, 0, 3);
      step("adv_wide", ADV, 0, 1, big, 1, big, 1, 0, 3);
      step("bub_valid", BUB, 0, 0, 'h1, 0, '0, 0, 1, 3);
      step("bub_idle", BUB, 0, 0, 'h2, 0, '0, 0, 1, 3);
      step("hold_empty", HLD, 0, 0, 'h3, 0, '0, 0, 1, 3);
      step("adv_inv", ADV, 0, 0, 'hAAAA, 0, 'hAAAA, 0, 1, 3);
      step("hold_empty2", HLD, 0, 1, 'h777, 0, 'hAAAA, 0, 1, 3);
      step("bub_inval", BUB, 0, 1, 'h999, 0, '0, 0, 2, 3);
      step("adv2", ADV, 0, 1, 'h9abc, 1, 'h9abc, 1, 2, 3);
      step("flush_hold", HLD, 1, 1, 'h4444, 0, '0, 0, 2, 3);
      step("adv3", ADV, 0, 1, 'hdef0, 1, 'hdef0, 1, 2, 3);
      step("hold4", HLD, 0, 1, 'h5, 1, 'hdef0, 2, 2, 4);
      step("flush_adv", ADV, 1, 1, 'h6, 0, '0, 0, 2, 4);
      step("flush_bub", BUB, 1, 1, 'h7, 0, '0, 0, 2, 4);
      step("adv4", ADV, 0, 1, 'h1111, 1, 'h1111, 1, 2, 4);
      step("hold5", HLD, 0, 1, 'h8, 1, 'h1111, 2, 2, 5);

      // Asynchronous reset pulse mid-hold, between clock edges.
      @(negedge clk);
      chk("pre_rst.valid", DW'(out_valid), 'd1);
      rst = 1'b1;
      #1;
      chk("arst.valid", DW'(out_valid), '0);
      chk("arst.data", out_data, '0);
      chk("arst.state", DW'(out_state), '0);
      chk("arst.bub", DW'(bubble_cnt), '0);
      chk("arst.hold", DW'(hold_cnt), '0);
      #1;
      rst = 1'b0;
      begin
         exp_t e;
         e.nm = "post_rst"; e.v = 0; e.d = '0; e.s = 0; e.b = 0; e.h = 0;
         sb.push_back(e);
      end

      step("adv5", ADV, 0, 1, 'h2222, 1, 'h2222, 1, 0, 0);
      step("other_bits", 6'b110011, 0, 1, 'h3333, 1, 'h3333, 1, 0, 0);
      step("hold_mix", 6'b111110, 0, 1, 'h9, 1, 'h3333, 2, 0, 1);
      step("bub_mix", 6'b110111, 0, 0, 'ha, 0, '0, 0, 1, 1);

      // Narrow-counter instance: 5 holds must saturate at 3.
      @(negedge clk);
      stall_b = ADV; in_valid_b = 1'b1; in_data_b = 'h55;
      @(negedge clk);
      stall_b = HLD;
      for (int i = 0; i < 5; i++) @(negedge clk);
      chk("b.state", DW'(out_state_b), 'd2);
      chk("b.data", out_data_b, 'h55);
      chk("b.hold_sat", DW'(hold_cnt_b), DW'(cexp(3)));
      chk("b.bub", DW'(bubble_cnt_b), '0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 141, meaning the payload width (aluop, alusel, reg1, reg2, wd, wreg and inst packed).
REQ-002 SHALL have parameter STALL_W, default 6, meaning the width of the global stall vector.
REQ-003 SHALL have parameter STAGE, default 2, meaning the index of this register's own bit in the stall vector.
REQ-004 SHALL have parameter NOP_VALUE, default all-zero DATA_W, meaning the bubble payload.
REQ-005 SHALL have parameter CNT_W, default 16, meaning the performance-counter width.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL provide port stall, input, STALL_W bits: the global stall vector, where 1 means Stop.
REQ-009 SHALL provide port flush, input, 1 bit: discard the stage contents.
REQ-010 SHALL provide port in_valid, input, 1 bit: the upstream payload is a real instruction.
REQ-011 SHALL provide port in_data, input, DATA_W bits: the upstream payload.
REQ-012 SHALL provide port out_valid, output, 1 bit: the registered valid flag.
REQ-013 SHALL provide port out_data, output, DATA_W bits: the registered payload.
REQ-014 SHALL provide port out_state, output, 2 bits: the FSM state (EMPTY=0, VALID=1, HELD=2).
REQ-015 SHALL provide port bubble_cnt, output, CNT_W bits: the number of bubbles inserted.
REQ-016 SHALL provide port hold_cnt, output, CNT_W bits: the number of cycles spent holding valid data.

Function
REQ-017 SHALL evaluate each clock edge with priority flush > bubble > hold > advance.
REQ-018 On flush=1, SHALL load out_data=NOP_VALUE and out_valid=0 and go to EMPTY, regardless of stall.
REQ-019 On a bubble (stall[STAGE]=1 and stall[STAGE+1]=0), SHALL load NOP_VALUE and out_valid=0 and go to EMPTY.
REQ-020 On a hold (stall[STAGE]=1 and stall[STAGE+1]=1), SHALL keep out_data/out_valid unchanged; VALID or HELD goes to HELD, EMPTY stays EMPTY.
REQ-021 On an advance (stall[STAGE]=0), SHALL load out_data=in_data and out_valid=in_valid, and go to VALID if in_valid=1, else EMPTY.
REQ-022 SHALL keep the latency from in_data to out_data at exactly one cycle on an advance.
REQ-023 SHALL register all outputs, with no combinational path from any input to any output.
REQ-024 SHALL fail elaboration when STAGE > STALL_W-2.
REQ-025 Counters SHALL saturate at all-ones and never wrap.
REQ-026 bubble_cnt SHALL increment only on a bubble transition taken while out_valid=1 or in_valid=1.
REQ-027 hold_cnt SHALL increment on each cycle that ends in HELD.
REQ-028 A flush SHALL NOT clear the counters.

Reset
REQ-029 While rst=1, SHALL asynchronously force out_data=NOP_VALUE, out_valid=0, out_state=EMPTY, bubble_cnt=0 and hold_cnt=0.
REQ-030 A reset asserted mid-hold or mid-bubble SHALL abandon that operation immediately; the first edge after release follows REQ-017.

Configuration
REQ-031 Macro PIPE_STAGE_PERF_EN defined: the counters SHALL operate per REQ-025 to REQ-028.
REQ-032 Macro PIPE_STAGE_PERF_EN undefined: the counter logic SHALL be absent, and bubble_cnt/hold_cnt SHALL be constant 0; all other behaviour is identical.

Structure
REQ-033 The shared package pipe_pkg SHALL hold the Stop/NoStop constants, the state encoding (EMPTY, VALID, HELD) and the default CNT_W.
REQ-034 SHALL use one sub-module, pipe_sat_counter (CNT_W wide, inc input, saturating, async reset), instantiated twice under PIPE_STAGE_PERF_EN.

Verification
REQ-035 SHALL check: rst pulse mid-cycle with out_valid=1 -> out_valid=0, out_data=NOP_VALUE, counters 0 before the next edge.
REQ-036 SHALL check: stall=0, in_valid=1, in_data=0x1234 -> next cycle out_data=0x1234, out_valid=1, out_state=VALID.
REQ-037 SHALL check: stall=6'b001100 for 3 cycles with VALID -> out_data held, out_state=HELD, hold_cnt=3.
REQ-038 SHALL check: stall=6'b000100 with VALID -> out_data=NOP_VALUE, out_valid=0, EMPTY, bubble_cnt=1.
REQ-039 SHALL check: flush=1 together with stall=6'b001100 -> EMPTY and NOP_VALUE next cycle; hold_cnt unchanged.
REQ-040 SHALL check: CNT_W=2 with 5 hold cycles -> hold_cnt=3 (saturated); with the macro undefined -> hold_cnt=0.
